// File: rtl/pulse_code_lock.sv
// Four-digit keypad code lock driven by debounced press pulses: collects digits,
// compares against CODE, and drives timed unlock, error and lockout outputs.
module pulse_code_lock #(
  parameter logic [7:0]  CODE           = 8'b11_10_01_00,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned UNLOCK_CYCLES  = 100_000_000,
  parameter int unsigned LOCKOUT_CYCLES = 500_000_000,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned CNTSIZE        = 29
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_pulse,
  output logic       unlocked,
  output logic       error_pulse,
  output logic       locked_out,
  output logic [2:0] digits_entered,
  output logic [2:0] fail_count
);

  localparam int TW = CNTSIZE + 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] UNLOCK_LAST  = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LOCKOUT_LAST = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0]    FAIL_LIMIT   = 3'(MAX_FAILS);

  typedef enum logic [1:0] {IDLE, ENTRY, OPEN, LOCKOUT} state_t;

  state_t        state, state_nx;
  logic [TW-1:0] timer, timer_nx, timer_inc;
  logic          mismatch, mismatch_nx;
  logic          unlocked_nx, error_nx, locked_nx;
  logic [2:0]    digits_nx, fails_nx;

  logic       press, multi, digit_bad, entry_bad;
  logic [1:0] digit;

  // Decode the press: several simultaneous bits form one digit that can never match.
  always_comb begin
    press = |btn_pulse;
    multi = (btn_pulse & (btn_pulse - 4'd1)) != 4'd0;
    case (btn_pulse)
      4'b0010: digit = 2'd1;
      4'b0100: digit = 2'd2;
      4'b1000: digit = 2'd3;
      default: digit = 2'd0;
    endcase
    digit_bad = multi | (digit != CODE[{digits_entered[1:0], 1'b0} +: 2]);
    entry_bad = mismatch | digit_bad;
    timer_inc = (timer == '1) ? timer : timer + TW'(1);
  end

  always_comb begin
    state_nx    = state;
    timer_nx    = timer;
    mismatch_nx = mismatch;
    unlocked_nx = unlocked;
    error_nx    = 1'b0;
    locked_nx   = locked_out;
    digits_nx   = digits_entered;
    fails_nx    = fail_count;
    case (state)
      IDLE: begin
        timer_nx = '0;
        if (press) begin
          mismatch_nx = digit_bad;
          digits_nx   = 3'd1;
          state_nx    = ENTRY;
        end
      end
      ENTRY: begin
        if (press) begin
          timer_nx = '0;
          if (digits_entered == 3'd3) begin
            digits_nx   = 3'd0;
            mismatch_nx = 1'b0;
            if (!entry_bad) begin
              unlocked_nx = 1'b1;
              fails_nx    = 3'd0;
              state_nx    = OPEN;
            end else begin
              error_nx = 1'b1;
              fails_nx = fail_count + 3'd1;
              if (fails_nx == FAIL_LIMIT) begin
                locked_nx = 1'b1;
                state_nx  = LOCKOUT;
              end else begin
                state_nx = IDLE;
              end
            end
          end else begin
            digits_nx   = digits_entered + 3'd1;
            mismatch_nx = entry_bad;
          end
        end else if (timer == TIMEOUT_LAST) begin
          // Partial entry abandoned; failures are only counted for complete codes.
          timer_nx    = '0;
          digits_nx   = 3'd0;
          mismatch_nx = 1'b0;
          state_nx    = IDLE;
        end else begin
          timer_nx = timer_inc;
        end
      end
      OPEN: begin
        if (timer == UNLOCK_LAST) begin
          timer_nx    = '0;
          unlocked_nx = 1'b0;
          state_nx    = IDLE;
        end else begin
          timer_nx = timer_inc;
        end
      end
      LOCKOUT: begin
        if (timer == LOCKOUT_LAST) begin
          timer_nx  = '0;
          locked_nx = 1'b0;
          fails_nx  = 3'd0;
          state_nx  = IDLE;
        end else begin
          timer_nx = timer_inc;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      timer          <= '0;
      mismatch       <= 1'b0;
      unlocked       <= 1'b0;
      error_pulse    <= 1'b0;
      locked_out     <= 1'b0;
      digits_entered <= 3'd0;
      fail_count     <= 3'd0;
    end else begin
      state          <= state_nx;
      timer          <= timer_nx;
      mismatch       <= mismatch_nx;
      unlocked       <= unlocked_nx;
      error_pulse    <= error_nx;
      locked_out     <= locked_nx;
      digits_entered <= digits_nx;
      fail_count     <= fails_nx;
    end
  end

endmodule

// File: tb/tb_pulse_code_lock.sv
// Randomized and directed bench for pulse_code_lock against a queue/countdown
// reference model of the keypad lock.
module tb_pulse_code_lock;

  localparam logic [7:0] CODE = 8'b11_10_01_00;
  localparam int T_TO   = 20;
  localparam int T_UN   = 10;
  localparam int T_LOCK = 30;
  localparam int MAXF   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_pulse = 4'd0;
  logic       unlocked, error_pulse, locked_out;
  logic [2:0] digits_entered, fail_count;

  int checks = 0;
  int errors = 0;

  pulse_code_lock #(
    .CODE(CODE), .TIMEOUT_CYCLES(T_TO), .UNLOCK_CYCLES(T_UN),
    .LOCKOUT_CYCLES(T_LOCK), .MAX_FAILS(MAXF), .CNTSIZE(29)
  ) dut (
    .clk(clk), .rst(rst), .btn_pulse(btn_pulse), .unlocked(unlocked),
    .error_pulse(error_pulse), .locked_out(locked_out),
    .digits_entered(digits_entered), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  // Reference model: entered digits as a queue (-1 = multi-press), plus countdowns.
  int q[$];
  int idle_cnt, open_left, lock_left, fails;
  bit m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int code_digit(input int k);
    logic [7:0] c;
    c = CODE;
    return int'(c[2*k +: 2]);
  endfunction

  task automatic model_reset();
    q.delete();
    idle_cnt = 0; open_left = 0; lock_left = 0; fails = 0; m_err = 0;
  endtask

  task automatic model_step(input logic [3:0] b);
    int d;
    bit ok;
    m_err = 0;
    if (open_left > 0) begin
      open_left--;
    end else if (lock_left > 0) begin
      lock_left--;
      if (lock_left == 0) fails = 0;
    end else if (b != 4'd0) begin
      d = -1;
      if ($onehot(b)) for (int i = 0; i < 4; i++) if (b[i]) d = i;
      q.push_back(d);
      idle_cnt = 0;
      if (q.size() == 4) begin
        ok = 1;
        for (int k = 0; k < 4; k++) if (q[k] != code_digit(k)) ok = 0;
        q.delete();
        if (ok) begin
          open_left = T_UN;
          fails = 0;
        end else begin
          m_err = 1;
          fails++;
          if (fails == MAXF) lock_left = T_LOCK;
        end
      end
    end else if (q.size() > 0) begin
      idle_cnt++;
      if (idle_cnt == T_TO) begin
        q.delete();
        idle_cnt = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("unlocked", unlocked, open_left > 0);
    chk("locked_out", locked_out, lock_left > 0);
    chk("error_pulse", error_pulse, m_err);
    chk("digits_entered", digits_entered, q.size());
    chk("fail_count", fail_count, fails);
    chk("exclusive", unlocked & locked_out, 0);
  endtask

  // Drive one cycle of input, update the model at the edge, sample 1 ns later.
  task automatic tick(input logic [3:0] b);
    btn_pulse = b;
    @(posedge clk);
    model_step(b);
    #1;
    compare_all();
    @(negedge clk);
    btn_pulse = 4'd0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(4'd0);
  endtask

  task automatic press_gap(input logic [3:0] b, input int gap);
    tick(b);
    idle(gap);
  endtask

  task automatic enter_code(input int d0, input int d1, input int d2, input int d3);
    tick(4'b1 << d0);
    tick(4'b1 << d1);
    tick(4'b1 << d2);
    tick(4'b1 << d3);
  endtask

  int cnt;
  int r;
  logic [3:0] b;

  initial begin
    model_reset();
    #12;
    chk("rst_unlocked", unlocked, 0);
    chk("rst_digits", digits_entered, 0);
    chk("rst_fails", fail_count, 0);
    @(negedge clk);
    rst = 1'b0;

    // Correct code with three idle cycles between pulses
    press_gap(4'b0001, 3); chk("d_step1", digits_entered, 1);
    press_gap(4'b0010, 3); chk("d_step2", digits_entered, 2);
    press_gap(4'b0100, 3); chk("d_step3", digits_entered, 3);
    tick(4'b1000);
    chk("d_step4", digits_entered, 0);
    chk("open_now", unlocked, 1);
    cnt = 1;
    for (int i = 0; i < 15; i++) begin
      tick(4'd0);
      if (unlocked) cnt++;
    end
    chk("unlock_len", cnt, T_UN);

    // Wrong code
    enter_code(0, 1, 2, 2);
    chk("wrong_err", error_pulse, 1);
    chk("wrong_fails", fail_count, 1);
    tick(4'd0);
    chk("err_one_cycle", error_pulse, 0);

    // Two more wrong codes trigger lockout; correct code during lockout is ignored
    enter_code(3, 3, 3, 3);
    enter_code(1, 0, 2, 3);
    chk("lock_now", locked_out, 1);
    cnt = 1;
    for (int i = 0; i < 4; i++) begin
      tick(4'b1 << i);
      if (locked_out) cnt++;
    end
    for (int i = 0; i < 35; i++) begin
      tick(4'd0);
      if (locked_out) cnt++;
    end
    chk("lock_len", cnt, T_LOCK);
    chk("lock_fails_clr", fail_count, 0);
    enter_code(0, 1, 2, 3);
    chk("post_lock_open", unlocked, 1);
    idle(12);

    // Timeout discards partial entry; late digits restart at position 0
    tick(4'b0001);
    tick(4'b0010);
    idle(19);
    chk("to_before", digits_entered, 2);
    tick(4'd0);
    chk("to_expire", digits_entered, 0);
    tick(4'b0100);
    tick(4'b1000);
    chk("to_late", digits_entered, 2);
    chk("to_noerr", error_pulse, 0);
    idle(22);

    // Press on the exact expiry cycle is accepted
    tick(4'b0001);
    idle(19);
    tick(4'b0010);
    chk("expiry_press", digits_entered, 2);
    idle(22);

    // Multi-bit press is a forced mismatch
    tick(4'b0011);
    tick(4'b0010);
    tick(4'b0100);
    tick(4'b1000);
    chk("multi_err", error_pulse, 1);
    chk("multi_open", unlocked, 0);
    idle(2);

    // Async reset mid-OPEN, between clock edges
    enter_code(0, 1, 2, 3);
    idle(3);
    chk("pre_rst_open", unlocked, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_drop", unlocked, 0);
    chk("async_fails", fail_count, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    enter_code(0, 1, 2, 3);
    chk("rst_reopen", unlocked, 1);
    idle(12);

    // Randomized traffic biased toward the correct next digit
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60) b = 4'd0;
      else if (r < 88) b = 4'b1 << code_digit(q.size() % 4);
      else if (r < 96) b = 4'b1 << $urandom_range(0, 3);
      else b = 4'($urandom_range(1, 15));
      tick(b);
      if ($urandom_range(0, 199) == 0) idle($urandom_range(18, 22));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
